// File: rtl/line_buffer_ctrl.sv
// Line-buffer sequencer: cascades two SRAM line buffers and builds a 3x3 sliding window.
// Optional build macro LB_CTRL_CFG_WIDTH_EN adds a run-time row width input (cfg_width).
module line_buffer_ctrl #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 30,
    parameter int unsigned IMG_WIDTH  = 28,
    parameter int unsigned IMG_HEIGHT = 28,
    parameter int unsigned ROW_WIDTH  = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    win_valid,
    output logic [9*DATA_WIDTH-1:0] win_data,
    output logic [ROW_WIDTH-1:0]    win_row,
    output logic [ADDR_WIDTH-1:0]   win_col,
    output logic [ADDR_WIDTH-1:0]   lb_rd_addr_I,
    output logic [ADDR_WIDTH-1:0]   lb_rd_addr_II,
    output logic [ADDR_WIDTH-1:0]   lb_wr_addr_I,
    output logic [ADDR_WIDTH-1:0]   lb_wr_addr_II,
    output logic                    lb_wr_en_I,
    output logic                    lb_wr_en_II,
    output logic [DATA_WIDTH-1:0]   lb_wr_data_I,
    output logic [DATA_WIDTH-1:0]   lb_wr_data_II,
    input  logic [DATA_WIDTH-1:0]   lb_rd_data_I,
    input  logic [DATA_WIDTH-1:0]   lb_rd_data_II
`ifdef LB_CTRL_CFG_WIDTH_EN
    ,
    input  logic [ADDR_WIDTH-1:0]   cfg_width
`endif
);

    localparam int unsigned EFF_WIDTH = (IMG_WIDTH <= DEPTH) ? IMG_WIDTH : DEPTH;
    localparam logic [ADDR_WIDTH-1:0] DEF_LAST_COL = ADDR_WIDTH'(EFF_WIDTH - 1);
    localparam logic [ROW_WIDTH-1:0]  LAST_ROW     = ROW_WIDTH'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   col;
    logic [ROW_WIDTH-1:0]    row;
    logic [ADDR_WIDTH-1:0]   last_col;
    logic                    s1_valid;
    logic [DATA_WIDTH-1:0]   s1_pix;
    logic [ADDR_WIDTH-1:0]   s1_col;
    logic [ROW_WIDTH-1:0]    s1_row;
    logic [9*DATA_WIDTH-1:0] win_next;
    logic                    accept;
    logic                    last_pix;
    logic                    s1_win;

    assign accept   = in_valid && in_ready;
    assign last_pix = (row == LAST_ROW) && (col == last_col);
    assign s1_win   = s1_valid && (s1_row >= ROW_WIDTH'(2)) && (s1_col >= ADDR_WIDTH'(2));

`ifdef LB_CTRL_CFG_WIDTH_EN
    logic [ADDR_WIDTH-1:0] cfg_last;

    // Clamp the requested width into 3..DEPTH, stored as the last column index
    always_comb begin
        cfg_last = cfg_width - ADDR_WIDTH'(1);
        if (cfg_width < ADDR_WIDTH'(3)) begin
            cfg_last = ADDR_WIDTH'(2);
        end else if (cfg_width > ADDR_WIDTH'(DEPTH)) begin
            cfg_last = ADDR_WIDTH'(DEPTH - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_col <= DEF_LAST_COL;
        end else if (state == IDLE && start) begin
            last_col <= cfg_last;
        end
    end
`else
    assign last_col = DEF_LAST_COL;
`endif

    // Stage 0 reads both buffers at the current column
    assign lb_rd_addr_I  = col;
    assign lb_rd_addr_II = col;

    // Stage 1 writes back: new pixel into I, the row I just read into II
    assign lb_wr_en_I    = s1_valid;
    assign lb_wr_en_II   = s1_valid;
    assign lb_wr_addr_I  = s1_col;
    assign lb_wr_addr_II = s1_col;
    assign lb_wr_data_I  = s1_pix;
    assign lb_wr_data_II = lb_rd_data_I;

    // Shift window left; new right column is {row r-2, row r-1, row r}
    always_comb begin
        win_next = win_data;
        for (int i = 0; i < 3; i++) begin
            win_next[DATA_WIDTH*(3*i) +: DATA_WIDTH]   = win_data[DATA_WIDTH*(3*i+1) +: DATA_WIDTH];
            win_next[DATA_WIDTH*(3*i+1) +: DATA_WIDTH] = win_data[DATA_WIDTH*(3*i+2) +: DATA_WIDTH];
        end
        win_next[DATA_WIDTH*2 +: DATA_WIDTH] = lb_rd_data_II;
        win_next[DATA_WIDTH*5 +: DATA_WIDTH] = lb_rd_data_I;
        win_next[DATA_WIDTH*8 +: DATA_WIDTH] = s1_pix;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            s1_valid   <= 1'b0;
            s1_pix     <= '0;
            s1_col     <= '0;
            s1_row     <= '0;
            win_valid  <= 1'b0;
            win_data   <= '0;
            win_row    <= '0;
            win_col    <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        col      <= '0;
                        row      <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (last_pix) begin
                            state    <= DRAIN;
                            in_ready <= 1'b0;
                            col      <= '0;
                            row      <= '0;
                        end else if (col == last_col) begin
                            col <= '0;
                            row <= row + ROW_WIDTH'(1);
                        end else begin
                            col <= col + ADDR_WIDTH'(1);
                        end
                    end
                end
                DRAIN: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    frame_done <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase

            s1_valid <= accept;
            if (accept) begin
                s1_pix <= in_data;
                s1_col <= col;
                s1_row <= row;
            end

            // Bubbles leave the window untouched so it stays coherent
            if (s1_valid) begin
                win_data <= win_next;
            end
            win_valid <= s1_win;
            if (s1_win) begin
                win_row <= s1_row;
                win_col <= s1_col;
            end
        end
    end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed bench for line_buffer_ctrl on a 5x4 frame with behavioural SRAM line buffers.
module tb_line_buffer_ctrl;

    localparam int AW = 5;
    localparam int DW = 16;
    localparam int RW = 5;
    localparam int W  = 5;
    localparam int H  = 4;
    localparam int NWIN = (W - 2) * (H - 2);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [DW-1:0]   in_data = '0;
    logic            busy, frame_done, win_valid;
    logic [9*DW-1:0] win_data;
    logic [RW-1:0]   win_row;
    logic [AW-1:0]   win_col;
    logic [AW-1:0]   rd_addr_1, rd_addr_2, wr_addr_1, wr_addr_2;
    logic            wr_en_1, wr_en_2;
    logic [DW-1:0]   wr_data_1, wr_data_2;
    logic [DW-1:0]   rd_data_1 = '0;
    logic [DW-1:0]   rd_data_2 = '0;
`ifdef LB_CTRL_CFG_WIDTH_EN
    logic [AW-1:0]   cfg_width = AW'(W);
`endif

    logic [DW-1:0] mem_1 [32];
    logic [DW-1:0] mem_2 [32];

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int win_idx = 0;
    int exp_wins = 0;
    int exp_base = 0;
    int fd_cnt = 0;
    int acc_cyc [W*H];

    line_buffer_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(30),
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .ROW_WIDTH(RW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .busy(busy), .frame_done(frame_done),
        .win_valid(win_valid), .win_data(win_data), .win_row(win_row), .win_col(win_col),
        .lb_rd_addr_I(rd_addr_1), .lb_rd_addr_II(rd_addr_2),
        .lb_wr_addr_I(wr_addr_1), .lb_wr_addr_II(wr_addr_2),
        .lb_wr_en_I(wr_en_1), .lb_wr_en_II(wr_en_2),
        .lb_wr_data_I(wr_data_1), .lb_wr_data_II(wr_data_2),
        .lb_rd_data_I(rd_data_1), .lb_rd_data_II(rd_data_2)
`ifdef LB_CTRL_CFG_WIDTH_EN
        , .cfg_width(cfg_width)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read SRAM models, read-before-write
    always @(posedge clk) begin
        rd_data_1 <= mem_1[rd_addr_1];
        rd_data_2 <= mem_2[rd_addr_2];
        if (wr_en_1) mem_1[wr_addr_1] <= wr_data_1;
        if (wr_en_2) mem_2[wr_addr_2] <= wr_data_2;
    end

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] pix(input int base, input int r, input int c);
        return DW'(base + 16 * r + c);
    endfunction

    // Window scoreboard: windows arrive in raster order over interior pixels
    always @(negedge clk) begin
        if (rst_n) begin
            if (win_valid) begin
                if (win_idx >= exp_wins) begin
                    check("extra_win", 160'(win_idx), 160'(exp_wins));
                end else begin
                    int er, ec;
                    logic [9*DW-1:0] ew;
                    er = 2 + win_idx / (W - 2);
                    ec = 2 + win_idx % (W - 2);
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            ew[DW*(3*i+j) +: DW] = pix(exp_base, er - 2 + i, ec - 2 + j);
                    check("win_row", 160'(win_row), 160'(er));
                    check("win_col", 160'(win_col), 160'(ec));
                    check("win_data", 160'(win_data), 160'(ew));
                    check("win_latency", 160'(cyc), 160'(acc_cyc[er*W+ec] + 2));
                end
                win_idx++;
            end
            if (frame_done) begin
                check("fd_with_win", 160'(win_valid), 160'(1));
                check("fd_win_count", 160'(win_idx), 160'(exp_wins));
                fd_cnt++;
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 160'(busy), 160'(0));
        check({tag, "_in_ready"}, 160'(in_ready), 160'(0));
        check({tag, "_win_valid"}, 160'(win_valid), 160'(0));
        check({tag, "_frame_done"}, 160'(frame_done), 160'(0));
        check({tag, "_wr_en"}, 160'({wr_en_1, wr_en_2}), 160'(0));
        check({tag, "_win_data"}, 160'(win_data), 160'(0));
        check({tag, "_win_pos"}, 160'({win_row, win_col}), 160'(0));
        check({tag, "_rd_addr"}, 160'({rd_addr_1, rd_addr_2}), 160'(0));
    endtask

    // Pixels offered while idle must be refused and leave the column counter alone
    task automatic idle_push();
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = DW'(16'hdead);
            check("idle_in_ready", 160'(in_ready), 160'(0));
            check("idle_rd_addr", 160'(rd_addr_1), 160'(0));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    // Called at posedge+1 of an IDLE (or frame_done) cycle; returns in the frame_done cycle
    task automatic run_frame(input int base, input bit gap, input int rst_at, input bit start_mid);
        int idx, budget;
        bit tog, acc;
        start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        exp_base = base;
        win_idx  = 0;
        exp_wins = (rst_at >= 0) ? 0 : NWIN;
        check("run_in_ready", 160'(in_ready), 160'(1));
        check("run_busy", 160'(busy), 160'(1));
        idx = 0; tog = 1'b0; budget = 0;
        while (idx < W * H && budget < 200) begin
            if (rst_at == idx) begin
                rst_n    = 1'b0;
                in_valid = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                check_idle_outputs("midrst");
                return;
            end
            in_valid = !(gap && tog);
            tog      = !tog;
            in_data  = pix(base, idx / W, idx % W);
            start    = start_mid && (idx == 7);
            acc      = in_valid && in_ready;
            if (acc) acc_cyc[idx] = cyc;
            @(posedge clk); #1;
            if (acc) idx++;
            budget++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        check("pixels_accepted", 160'(idx), 160'(W * H));
        budget = 0;
        while (!frame_done && budget < 20) begin
            @(posedge clk); #1;
            budget++;
        end
        check("frame_done_seen", 160'(frame_done), 160'(1));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Continuous stream
        run_frame(32'h000, 1'b0, -1, 1'b0);
        @(posedge clk); #1;
        check("post_frame_busy", 160'(busy), 160'(0));
        idle_push();

        // Bubbles every other cycle, plus a start pulse while busy
        run_frame(32'h200, 1'b1, -1, 1'b1);
        // Back-to-back: next start lands in the frame_done cycle
        run_frame(32'h400, 1'b0, -1, 1'b0);
        @(posedge clk); #1;

        // Reset at pixel (2,3), then recover
        run_frame(32'h600, 1'b0, 2 * W + 3, 1'b0);
        idle_push();
        run_frame(32'h800, 1'b0, -1, 1'b0);
        @(posedge clk); #1;
        check("frame_done_total", 160'(fd_cnt), 160'(4));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
